// File: rtl/param_fifo_core.sv
// param_fifo_core: parameterised synchronous FIFO with show-ahead read port.
//
// Occupancy is tracked by an explicit counter. Almost-full and almost-empty
// flags are derived from it, and a high-water mark (peak) records the largest
// occupancy seen since the last reset or flush.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. Ready/valid never depend on the other
// side's valid/ready in the same cycle, except for the optional bypass path.
//
// Optional feature: define PARAM_FIFO_BYPASS_EN to let a word written into an
// empty FIFO appear on data_out in the same cycle. If out_rdy is 1 in that
// cycle the word is consumed without being stored. Without the macro there is
// no combinational path from the write side to the read side.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   clk_en       global enable; 0 freezes all state and drops both readies/valids
//   flush        synchronous clear of contents, pointers and peak
//   in_vld       write request
//   in_rdy       FIFO can accept a word
//   data_in      write payload
//   out_vld      head-of-queue word available
//   out_rdy      consumer accepts the head word
//   data_out     head-of-queue payload (don't-care while out_vld=0)
//   count        current occupancy (0..DEPTH)
//   almost_full  count >= AFULL_TH
//   almost_empty count <= AEMPTY_TH
//   peak         high-water mark of count
module param_fifo_core #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic                       flush,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     peak
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic [CW-1:0]         peak_q;
  logic [CW-1:0]         peak_d;

  logic enabled;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_adv;

  // Reset is folded in combinationally so both handshakes drop immediately
  // while rst is low, not only after the next edge.
  assign enabled = rst & clk_en & ~flush;
  assign in_rdy  = enabled & (count_q < DEPTH_C);
  assign push    = in_vld & in_rdy;

`ifdef PARAM_FIFO_BYPASS_EN
  logic bypass_take;

  // When empty, the incoming word is presented directly. If it is taken in
  // the same cycle it never touches storage or the pointers.
  assign out_vld     = enabled & ((count_q != '0) | push);
  assign data_out    = (count_q == '0) ? data_in : mem[rd_ptr];
  assign pop         = out_vld & out_rdy;
  assign bypass_take = (count_q == '0) & pop;
  assign wr_en       = push & ~bypass_take;
  assign rd_adv      = pop & ~bypass_take;
`else
  assign out_vld  = enabled & (count_q != '0);
  assign data_out = mem[rd_ptr];
  assign pop      = out_vld & out_rdy;
  assign wr_en    = push;
  assign rd_adv   = pop;
`endif

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_adv) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && rd_adv) begin
      count_d = count_q - CW'(1);
    end
  end

  assign peak_d = (count_d > peak_q) ? count_d : peak_q;

  // Control state. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      peak_q  <= '0;
    end else if (clk_en) begin
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
        peak_q  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
        count_q <= count_d;
        peak_q  <= peak_d;
      end
    end
  end

  // Storage is deliberately not reset; stale contents are unreachable once
  // the pointers and count are cleared. wr_en already includes clk_en, flush
  // and rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  assign count        = count_q;
  assign peak         = peak_q;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

endmodule

// File: doc/param_fifo_core.md
PARAM_FIFO_CORE -- requirements
Module: param_fifo_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of storage entries (power of two, >=2).
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, almost-full threshold in entries (1..DEPTH).
REQ-004 SHALL have parameter AEMPTY_TH, default 1, almost-empty threshold in entries (0..DEPTH-1).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst.
REQ-006 SHALL have ports: clk  in  1  rising-edge clock.
REQ-007 SHALL have ports: rst  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: clk_en  in  1  global enable; 0 freezes all state.
REQ-009 SHALL have ports: flush  in  1  synchronous clear of contents.
REQ-010 SHALL have ports: in_vld / in_rdy  in / out  1 / 1  write handshake.
REQ-011 SHALL have ports: data_in  in  DATA_WIDTH  write payload.
REQ-012 SHALL have ports: out_vld / out_rdy  out / in  1 / 1  read handshake.
REQ-013 SHALL have ports: data_out  out  DATA_WIDTH  head-of-queue payload.
REQ-014 SHALL have ports: count  out  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have ports: almost_full / almost_empty  out  1 / 1  threshold flags.
REQ-016 SHALL have ports: peak  out  $clog2(DEPTH)+1  high-water mark since reset/flush.

Function
REQ-017 SHALL assert in_rdy = rst & clk_en & !flush & (count<DEPTH); a push occurs when in_vld & in_rdy.
REQ-018 SHALL assert out_vld = rst & clk_en & !flush & (count>0); a pop occurs when out_vld & out_rdy.
REQ-019 SHALL present data_out = mem[rd_ptr] (show-ahead); data_out is don't-care while out_vld=0.
REQ-020 SHALL, on push, write mem[wr_ptr] and advance wr_ptr modulo DEPTH; on pop, advance rd_ptr modulo DEPTH.
REQ-021 SHALL update count: +1 push only, -1 pop only, unchanged on both or neither; never exceeds DEPTH, never underflows.
REQ-022 SHALL make a pushed word visible at data_out with out_vld=1 no earlier than the next rising edge (1-cycle latency) when the FIFO is empty.
REQ-023 SHALL deassert in_rdy when full even if out_rdy=1 (no pass-through on full).
REQ-024 SHALL preserve strict FIFO order across pointer wrap-around.
REQ-025 SHALL drive almost_full = (count>=AFULL_TH) and almost_empty = (count<=AEMPTY_TH), combinational from count.
REQ-026 SHALL update peak to max(peak, next count) on every enabled edge.
REQ-027 SHALL, when flush=1 and clk_en=1, clear count, pointers and peak to 0 at the edge; any same-cycle push/pop is ignored.
REQ-028 SHALL hold every register when clk_en=0, including across flush.

Reset
REQ-029 SHALL, while rst=0, immediately force count=0, wr_ptr=0, rd_ptr=0, peak=0, in_rdy=0, out_vld=0, almost_empty=1, almost_full=0.
REQ-030 SHALL NOT reset storage contents; reset asserted mid-transfer discards all queued data.

Configuration
REQ-031 SHALL recognise macro PARAM_FIFO_BYPASS_EN.
REQ-032 SHALL, with PARAM_FIFO_BYPASS_EN defined and count=0, drive out_vld=in_vld & in_rdy and data_out=data_in combinationally; if out_rdy=1 the word is consumed without being stored and count stays 0.
REQ-033 SHALL, without PARAM_FIFO_BYPASS_EN, have no combinational path from in_vld/data_in to out_vld/data_out (REQ-022 latency applies).

Verification
REQ-034 SHALL cover: DEPTH=16, push 0x0001..0x0010 with out_rdy=0 -> count=16, in_rdy=0, almost_full=1 from count 14, peak=16.
REQ-035 SHALL cover: full FIFO, in_vld=1 and out_rdy=1 for 1 cycle -> pop 0x0001 only, count=15.
REQ-036 SHALL cover: 40 continuous pushes/pops at count 5 -> output sequence equals input order across 2+ wraps, count stays 5.
REQ-037 SHALL cover: count=7, flush=1, in_vld=1 -> next cycle count=0, peak=0, out_vld=0, pushed word absent.
REQ-038 SHALL cover: count=4, clk_en=0 for 3 cycles with in_vld=out_rdy=1 -> count, pointers, peak unchanged, in_rdy=out_vld=0.
REQ-039 SHALL cover: empty, push 0xBEEF with out_rdy=1 -> bypass build: out_vld=1, data_out=0xBEEF same cycle, count stays 0; non-bypass build: out_vld=1 next cycle.
